pwm_multi_driver: RTL and testbench
===================================

# pwm_multi_driver

Multi-channel, parametrised PWM generator that supersedes the single-channel fixed-12-bit driver. All CHANNELS outputs share one counter with a programmable period. The block supports edge-aligned and center-aligned counting. Duty, period and mode pass through shadow registers and take effect only at a period boundary, so outputs never glitch. It sits between the host register interface (okWire/trigger side) and the motor/LED output pins.

## Interface
- WIDTH, 12, bit width of counter, period and each duty value
- CHANNELS, 4, number of independent PWM outputs (≥1)
- CLK  in  1  system clock, all logic on posedge
- RST  in  1  reset, synchronous, active-high
- EN  in  1  run enable; low holds counter idle and forces outputs low
- MODE  in  1  0 = edge-aligned, 1 = center-aligned; sampled on LOAD
- PERIOD  in  WIDTH  period value P; sampled on LOAD
- DUTY  in  CHANNELS*WIDTH  duty D[i] = DUTY[i*WIDTH +: WIDTH]; sampled on LOAD
- LOAD  in  1  one-cycle strobe; captures MODE/PERIOD/DUTY into pending registers
- PWM_OUT  out  CHANNELS  registered PWM outputs
- PERIOD_END  out  1  one-cycle pulse when the counter restarts at 0
- PENDING  out  1  high while captured values await application

## Operation
- Reset values: counter 0, direction up, active P = all ones, active D[i] = 0, active mode edge, PWM_OUT = 0, PERIOD_END = 0, PENDING = 0, pending registers 0.
- Edge mode: the counter runs 0,1,…,P and then returns to 0. The period is P+1 cycles. The terminal cycle is cnt == P.
- Center mode with P ≥ 1: the counter runs up 0..P, then down P-1..1, then returns to 0. The period is 2P cycles. The terminal cycle is cnt == 1 going down, or cnt == P when P == 1.
- Center mode with P == 0: the counter stays at 0 and every cycle is terminal.
- Compare: next PWM_OUT[i] = EN & (cnt < D[i]), using an unsigned WIDTH-bit compare.
- High cycles per period, edge mode: min(D, P+1). D = 0 gives constant low; D > P gives constant high.
- High cycles per period, center mode: 0 if D = 0; 2D-1 if 1 ≤ D ≤ P; 2P if D > P. The pulse is symmetric about cnt = 0.
- Shadow update: LOAD copies the inputs into the pending registers and sets PENDING.
  - A second LOAD before the boundary overwrites the pending values. Only the last LOAD is applied.
  - At the clock edge that ends a terminal cycle, pending values become active and PENDING clears. The counter returns to 0 and the direction resets to up.
- LOAD in the terminal cycle itself: the values are captured into pending and take effect at the next boundary, not this one. PENDING stays set through this boundary.
- EN = 0:
  - Counter is held at 0, direction up, PWM_OUT driven 0 from the next edge, PERIOD_END is 0.
  - LOAD is still accepted. Pending values apply at the next edge and PENDING clears that cycle.
- EN 0→1: counting starts from 0 with the currently active values.
- P reduced below the current count: no effect until the boundary, because P only changes at a wrap. The counter cannot overrun.
- Counter arithmetic is WIDTH bits. P = all ones in edge mode gives a wrap of 2^WIDTH cycles with no overflow error.
- RST mid-period: all state returns to reset values at the next edge, and any pending LOAD is discarded.

## Timing
- PWM_OUT latency: one cycle. PWM_OUT at cycle k reflects cnt and active D at cycle k-1.
- PERIOD_END is registered. It is high exactly in the cycle where cnt = 0 following a terminal cycle, and never while EN = 0.
- First counted cycle after reset release with EN = 1: cnt = 0 and PERIOD_END = 0. The first PERIOD_END occurs after the first full period.
- Active values change on the same edge that asserts PERIOD_END. The new duty is therefore first visible on PWM_OUT one cycle after PERIOD_END.
- PENDING rises on the edge after LOAD and falls on the edge that applies the values.

## Test plan
- Edge mode, WIDTH = 12, P = 9, D = {0,3,10,4095}, EN = 1 → per 10-cycle period, PWM_OUT high counts {0,3,10,10}. PERIOD_END occurs every 10 cycles.
- Center mode, P = 4, D[0] = 2, D[1] = 5 → period 8 cycles. Channel 0 is high for 3 cycles, centered on cnt = 0. Channel 1 is constant high.
- Shadow update: running P = 9, D = 3, LOAD D = 7 at cnt = 2 → PENDING goes high. Duty stays 3 until the boundary, PENDING clears at the PERIOD_END cycle, and the next period shows 7 high cycles. A LOAD in the terminal cycle (cnt = 9) is applied one period later.
- Double LOAD: D = 5 then D = 6 within one period → only 6 is applied. There is no intermediate period with 5.
- EN low mid-period at cnt = 5 → PWM_OUT = 0 on the next cycle, counter at 0, no PERIOD_END. A LOAD while EN is low applies on the next edge. EN high again → counting restarts from 0.
- RST asserted mid-period with PENDING = 1 → the next cycle shows all outputs 0, PENDING = 0, and active D = 0. Channels stay low after RST releases until the next LOAD.

Source files
------------

// File: rtl/pwm_multi_driver.sv
// Multi-channel PWM generator sharing one edge/center-aligned counter.
// Mode, period and duty are double-buffered and applied only at a period boundary.
module pwm_multi_driver #(
  parameter int WIDTH    = 12,
  parameter int CHANNELS = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      en_i,
  input  logic                      mode_i,
  input  logic [WIDTH-1:0]          period_i,
  input  logic [CHANNELS*WIDTH-1:0] duty_i,
  input  logic                      load_i,
  output logic [CHANNELS-1:0]       pwm_out_o,
  output logic                      period_end_o,
  output logic                      pending_o
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  logic [WIDTH-1:0]          cnt_q, cnt_d;
  logic                      dir_down_q, dir_down_d;
  logic [WIDTH-1:0]          act_p_q, act_p_d;
  logic                      act_mode_q, act_mode_d;
  logic [CHANNELS*WIDTH-1:0] act_duty_q, act_duty_d;
  logic [WIDTH-1:0]          pend_p_q, pend_p_d;
  logic                      pend_mode_q, pend_mode_d;
  logic [CHANNELS*WIDTH-1:0] pend_duty_q, pend_duty_d;
  logic                      pending_q, pending_d;
  logic [CHANNELS-1:0]       pwm_q, pwm_d;
  logic                      pe_q, pe_d;
  logic                      term;
  logic                      apply;

  always_comb begin
    cnt_d       = cnt_q;
    dir_down_d  = dir_down_q;
    act_p_d     = act_p_q;
    act_mode_d  = act_mode_q;
    act_duty_d  = act_duty_q;
    pend_p_d    = pend_p_q;
    pend_mode_d = pend_mode_q;
    pend_duty_d = pend_duty_q;
    pwm_d       = '0;

    // Terminal cycle: last count before the counter returns to 0.
    if (act_mode_q) begin
      term = (act_p_q == ZERO) || ((act_p_q == ONE) && (cnt_q == ONE)) ||
             (dir_down_q && (cnt_q == ONE));
    end else begin
      term = (cnt_q == act_p_q);
    end

    if (!en_i || term) begin
      cnt_d      = ZERO;
      dir_down_d = 1'b0;
    end else if (!act_mode_q) begin
      cnt_d = cnt_q + ONE;
    end else if (dir_down_q) begin
      cnt_d = cnt_q - ONE;
    end else if (cnt_q == act_p_q) begin
      dir_down_d = 1'b1;
      cnt_d      = cnt_q - ONE;
    end else begin
      cnt_d = cnt_q + ONE;
    end

    for (int i = 0; i < CHANNELS; i++) begin
      pwm_d[i] = en_i && (cnt_q < act_duty_q[i*WIDTH +: WIDTH]);
    end
    pe_d = en_i && term;

    // Idle (EN low) counts as a boundary so a held block still takes new values.
    apply = pending_q && (term || !en_i);
    if (apply) begin
      act_p_d    = pend_p_q;
      act_mode_d = pend_mode_q;
      act_duty_d = pend_duty_q;
    end
    if (load_i) begin
      pend_p_d    = period_i;
      pend_mode_d = mode_i;
      pend_duty_d = duty_i;
    end
    pending_d = load_i || (pending_q && !apply);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q       <= ZERO;
      dir_down_q  <= 1'b0;
      act_p_q     <= '1;
      act_mode_q  <= 1'b0;
      act_duty_q  <= '0;
      pend_p_q    <= ZERO;
      pend_mode_q <= 1'b0;
      pend_duty_q <= '0;
      pending_q   <= 1'b0;
      pwm_q       <= '0;
      pe_q        <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      dir_down_q  <= dir_down_d;
      act_p_q     <= act_p_d;
      act_mode_q  <= act_mode_d;
      act_duty_q  <= act_duty_d;
      pend_p_q    <= pend_p_d;
      pend_mode_q <= pend_mode_d;
      pend_duty_q <= pend_duty_d;
      pending_q   <= pending_d;
      pwm_q       <= pwm_d;
      pe_q        <= pe_d;
    end
  end

  assign pwm_out_o    = pwm_q;
  assign period_end_o = pe_q;
  assign pending_o    = pending_q;

endmodule

// File: tb/tb_pwm_multi_driver.sv
// Directed bench for pwm_multi_driver: per-cycle comparison against a period-position
// model plus hand-computed high-cycle counts and boundary spacings.
module tb_pwm_multi_driver;
  localparam int W  = 12;
  localparam int CH = 4;

  logic            clk = 1'b0;
  logic            rst, en, mode, load;
  logic [W-1:0]    period;
  logic [CH*W-1:0] duty;
  logic [CH-1:0]   pwm;
  logic            pe, pending;

  pwm_multi_driver #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode), .period_i(period),
    .duty_i(duty), .load_i(load), .pwm_out_o(pwm), .period_end_o(pe),
    .pending_o(pending)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: position t within the current period, counter value derived from t.
  int m_t, m_P, pP;
  bit m_mode, pmode, m_pend;
  int m_D[CH];
  int pD[CH];
  logic [CH-1:0] e_pwm;
  logic e_pe, e_pending;

  always @(posedge clk) begin
    int len, cnt;
    bit term, apply;
    if (rst) begin
      m_t = 0; m_P = (1 << W) - 1; m_mode = 0; m_pend = 0; pP = 0; pmode = 0;
      for (int i = 0; i < CH; i++) begin m_D[i] = 0; pD[i] = 0; end
      e_pwm = '0; e_pe = 0; e_pending = 0;
    end else begin
      len = m_mode ? ((m_P == 0) ? 1 : 2 * m_P) : m_P + 1;
      cnt = (!m_mode || m_t <= m_P) ? m_t : 2 * m_P - m_t;
      term = en && (m_t == len - 1);
      for (int i = 0; i < CH; i++) e_pwm[i] = en && (cnt < m_D[i]);
      e_pe = term;
      apply = m_pend && (term || !en);
      m_t = (!en || term) ? 0 : m_t + 1;
      if (apply) begin
        m_P = pP; m_mode = pmode;
        for (int i = 0; i < CH; i++) m_D[i] = pD[i];
      end
      if (load) begin
        pP = int'(period); pmode = mode; m_pend = 1;
        for (int i = 0; i < CH; i++) pD[i] = int'(duty[i*W +: W]);
      end else if (apply) begin
        m_pend = 0;
      end
      e_pending = m_pend;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_pwm", 32'(pwm), 32'(e_pwm));
      chk("cyc_period_end", 32'(pe), 32'(e_pe));
      chk("cyc_pending", 32'(pending), 32'(e_pending));
    end
  end

  function automatic logic [CH*W-1:0] mkduty(input int d0, input int d1, input int d2, input int d3);
    logic [CH*W-1:0] v;
    v = {W'(d3), W'(d2), W'(d1), W'(d0)};
    return v;
  endfunction

  task automatic do_load(input bit md, input int p, input logic [CH*W-1:0] d);
    mode = md; period = W'(p); duty = d; load = 1;
    @(negedge clk);
    load = 0;
  endtask

  task automatic wait_pe(input int bound, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pe && n < bound);
    if (!pe) chk("wait_period_end_timeout", 32'(n), 32'(bound + 1));
  endtask

  int hi[CH];
  int pe_cnt;
  int ld_at[2] = '{-1, -1};
  logic [CH*W-1:0] ld_duty[2];

  // Counts high cycles over one period starting from a PERIOD_END cycle.
  task automatic count_period(input int len);
    for (int c = 0; c < CH; c++) hi[c] = 0;
    pe_cnt = 0;
    for (int j = 1; j <= len; j++) begin
      @(negedge clk);
      load = 0;
      for (int k = 0; k < 2; k++) if (ld_at[k] == j) begin duty = ld_duty[k]; load = 1; end
      for (int c = 0; c < CH; c++) if (pwm[c]) hi[c]++;
      if (pe) pe_cnt++;
    end
    ld_at[0] = -1; ld_at[1] = -1;
  endtask

  initial begin
    int n;
    rst = 1; en = 0; mode = 0; load = 0; period = '0; duty = '0;
    @(negedge clk);
    chk_en = 1;
    @(negedge clk);
    chk("reset_pwm", 32'(pwm), 0);
    chk("reset_period_end", 32'(pe), 0);
    chk("reset_pending", 32'(pending), 0);

    // Reset period is all ones: full 4096-cycle wrap.
    rst = 0; en = 1;
    wait_pe(5000, n);
    chk("wrap_4096", n, 4096);

    // Load edge config while idle; applies on the following edge.
    en = 0;
    do_load(0, 9, mkduty(0, 3, 10, 4095));
    chk("idle_load_pending", 32'(pending), 1);
    @(negedge clk);
    chk("idle_load_applied", 32'(pending), 0);
    en = 1;
    wait_pe(50, n);
    chk("edge_spacing", n, 10);
    count_period(10);
    chk("edge_hi0", hi[0], 0);
    chk("edge_hi1", hi[1], 3);
    chk("edge_hi2", hi[2], 10);
    chk("edge_hi3", hi[3], 10);
    chk("edge_pe_per_period", pe_cnt, 1);

    // Center mode P=4.
    do_load(1, 4, mkduty(2, 5, 0, 4095));
    wait_pe(50, n);
    count_period(8);
    chk("ctr_hi0", hi[0], 3);
    chk("ctr_hi1", hi[1], 8);
    chk("ctr_hi2", hi[2], 0);
    chk("ctr_hi3", hi[3], 8);
    chk("ctr_pe_per_period", pe_cnt, 1);
    wait_pe(50, n);
    chk("ctr_spacing", n, 8);

    do_load(1, 1, mkduty(2, 5, 0, 4095));
    wait_pe(50, n);
    wait_pe(50, n);
    chk("ctr_p1_spacing", n, 2);
    do_load(1, 0, mkduty(2, 5, 0, 4095));
    wait_pe(50, n);
    wait_pe(50, n);
    chk("ctr_p0_spacing", n, 1);

    // Shadow update tests on edge P=9.
    do_load(0, 9, mkduty(3, 0, 10, 4095));
    wait_pe(50, n);
    ld_at[0] = 2; ld_duty[0] = mkduty(7, 0, 10, 4095);
    count_period(10);
    chk("shadow_old_duty", hi[0], 3);
    chk("shadow_pending_cleared", 32'(pending), 0);
    ld_at[0] = 9; ld_duty[0] = mkduty(8, 0, 10, 4095);
    count_period(10);
    chk("shadow_new_duty", hi[0], 7);
    chk("term_load_still_pending", 32'(pending), 1);
    count_period(10);
    chk("term_load_not_yet", hi[0], 7);
    chk("term_load_cleared", 32'(pending), 0);
    ld_at[0] = 2; ld_duty[0] = mkduty(5, 0, 10, 4095);
    ld_at[1] = 4; ld_duty[1] = mkduty(6, 0, 10, 4095);
    count_period(10);
    chk("term_load_applied", hi[0], 8);
    count_period(10);
    chk("double_load_last", hi[0], 6);

    // EN low mid-period.
    repeat (5) @(negedge clk);
    en = 0;
    @(negedge clk);
    chk("en_low_pwm", 32'(pwm), 0);
    chk("en_low_pe", 32'(pe), 0);
    duty = mkduty(9, 0, 10, 4095); load = 1;
    @(negedge clk);
    load = 0;
    chk("en_low_load_pending", 32'(pending), 1);
    @(negedge clk);
    chk("en_low_load_applied", 32'(pending), 0);
    en = 1;
    wait_pe(50, n);
    chk("en_restart_spacing", n, 10);
    count_period(10);
    chk("en_restart_duty", hi[0], 9);

    // Reset with a pending load.
    do_load(0, 9, mkduty(2, 2, 2, 2));
    chk("rst_pre_pending", 32'(pending), 1);
    rst = 1;
    @(negedge clk);
    chk("rst_pwm", 32'(pwm), 0);
    chk("rst_pending", 32'(pending), 0);
    rst = 0;
    count_period(20);
    chk("post_rst_hi0", hi[0], 0);
    chk("post_rst_hi3", hi[3], 0);
    chk("post_rst_pe", pe_cnt, 0);

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
